refill_axi_sched: RTL and testbench
===================================

# refill_axi_sched

Refill scheduler sharing one AXI read channel between the instruction-cache and data-cache miss paths. Arbitrates pending line requests round-robin, issues one aligned INCR burst per request, assembles returning R beats into a full line, and hands the line back to the granted requester with a valid/ready handshake. It sits between the cache refill logic and the AXI master port, one outstanding burst at a time.

## Interface

- DW, 8, R-channel data width in bits (power of two, ≥8)
- NB, 2, beats per cache line (2..16)
- AW, 32, address width

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- dc_req_valid_i / dc_req_ready_o  in/out  1  dcache miss request handshake
- dc_req_addr_i  in  AW  dcache miss address
- ic_req_valid_i / ic_req_ready_o  in/out  1  icache miss request handshake
- ic_req_addr_i  in  AW  icache miss address
- ar_valid_o / ar_ready_i  out/in  1  AXI AR handshake
- ar_addr_o  out  AW  line-aligned burst address
- ar_len_o  out  8  constant NB-1
- ar_id_o  out  1  0 = dcache, 1 = icache
- r_valid_i / r_ready_o  in/out  1  AXI R handshake
- r_data_i  in  DW  beat data
- r_last_i  in  1  last beat of burst
- r_resp_i  in  2  beat response (non-zero = error)
- line_valid_o / line_ready_i  out/in  1  completed-line handshake
- line_data_o  out  NB*DW  assembled line, beat k at bits [k*DW +: DW]
- line_dst_o  out  1  0 = dcache, 1 = icache
- line_err_o  out  1  burst had an error or length mismatch

## Operation

- FSM: IDLE → AR → DATA → (DRAIN) → DONE → IDLE.
- IDLE: exactly one req_ready_o high, to the arbitration winner among valid requesters; both low if none valid. On handshake, latch the address with the low log2(NB*DW/8) bits cleared, latch the destination, clear the line buffer, beat counter and error flag, go to AR.
- Arbitration: round-robin with a 1-bit last-granted pointer. After reset dcache has priority. With both valid, the requester not granted last wins. A single valid requester always wins.
- AR: ar_valid_o high, address/len/id stable until ar_ready_i. Then go to DATA.
- DATA: r_ready_o high. Each accepted beat is written to slot beat_cnt, and beat_cnt increments. Any r_resp_i ≠ 0 sets the error flag.
  - r_last_i on beat NB-1: go to DONE.
  - r_last_i before beat NB-1 (short burst): set error, leave the unfilled slots zero, go to DONE.
  - Beat NB-1 without r_last_i (long burst): set error, go to DRAIN.
- DRAIN: r_ready_o high. Discard beats until r_last_i, then go to DONE.
- DONE: line_valid_o high; data, dst and err stable until line_ready_i. Then go to IDLE and update the round-robin pointer.
- Requests are not accepted outside IDLE. Requesters must hold valid and address until ready.
- Reset values: state IDLE, all *_ready_o/*_valid_o 0, ar_addr_o 0, ar_id_o 0, line_data_o 0, line_dst_o 0, line_err_o 0, pointer = "icache last". Reset mid-burst abandons the burst. Outstanding R beats after reset are the interconnect's concern.

## Timing

- ar_valid_o, r_ready_o and line_valid_o are registered state decodes. req_ready_o is combinational from state and the valid inputs.
- Minimum latency, with ar_ready_i and r_valid_i always high:
  - request handshake at cycle 0
  - ar_valid_o at cycle 1, AR handshake at cycle 1
  - first beat at cycle 2, last beat at cycle NB+1
  - line_valid_o at cycle NB+2
- DONE with line_ready_i already high: line_valid_o lasts 1 cycle, and the next request can be accepted in the following cycle.
- Back-to-back throughput: one line per NB+3 cycles.
- AR and R are never active in the same cycle (single outstanding burst).

## Test plan

- Reset, then dc request at 0x1003 (DW=8, NB=2) → ar_addr_o=0x1002, ar_len_o=1, ar_id_o=0. Beats 0xAA, 0xBB (last on 2nd) → line_data_o=0xBBAA, dst 0, err 0, line_valid_o at cycle 4.
- ic and dc valid in the same cycle, repeated three times → grant order dc, ic, dc. The losing requester's ready stays 0 until its turn.
- Short burst: r_last_i on beat 0 with data 0x5C → line_data_o=0x005C, err 1.
- Long burst: 4 beats, r_last_i on the 4th → first two beats kept, last two discarded, err 1, r_ready_o held through the 4th beat.
- r_resp_i=2'b10 on beat 1 → err 1, data still assembled. line_ready_i held low 5 cycles → line_valid_o and line_data_o stable throughout.
- rst_i pulsed during DATA after 1 beat → next cycle all outputs at reset values. A new ic request then completes normally.

Source files
------------

// File: rtl/refill_axi_sched.sv
// Refill scheduler: shares one AXI read channel between the dcache and icache miss paths.
// Round-robin arbitration, one aligned INCR burst per request, line assembly and hand-back.
module refill_axi_sched #(
  parameter int unsigned DW = 8,
  parameter int unsigned NB = 2,
  parameter int unsigned AW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dc_req_valid_i,
  output logic             dc_req_ready_o,
  input  logic [AW-1:0]    dc_req_addr_i,
  input  logic             ic_req_valid_i,
  output logic             ic_req_ready_o,
  input  logic [AW-1:0]    ic_req_addr_i,
  output logic             ar_valid_o,
  input  logic             ar_ready_i,
  output logic [AW-1:0]    ar_addr_o,
  output logic [7:0]       ar_len_o,
  output logic             ar_id_o,
  input  logic             r_valid_i,
  output logic             r_ready_o,
  input  logic [DW-1:0]    r_data_i,
  input  logic             r_last_i,
  input  logic [1:0]       r_resp_i,
  output logic             line_valid_o,
  input  logic             line_ready_i,
  output logic [NB*DW-1:0] line_data_o,
  output logic             line_dst_o,
  output logic             line_err_o
);

  localparam int unsigned LineBytes = NB * DW / 8;
  localparam int unsigned OffW      = $clog2(LineBytes);
  localparam int unsigned CntW      = $clog2(NB);
  localparam logic [AW-1:0]   AlignMask = ~((AW'(1) << OffW) - AW'(1));
  localparam logic [CntW-1:0] LastBeat  = CntW'(NB - 1);

  typedef enum logic [2:0] {StIdle, StAr, StData, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               dst_q, dst_d;     // 0 = dcache, 1 = icache
  logic               err_q, err_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NB*DW-1:0]   line_q, line_d;
  logic               last_q, last_d;   // last granted requester, 1 = icache
  logic               dc_win, ic_win;

  // Round-robin arbitration; request ready only while idle.
  always_comb begin
    dc_win         = dc_req_valid_i && (!ic_req_valid_i || last_q);
    ic_win         = ic_req_valid_i && (!dc_req_valid_i || !last_q);
    dc_req_ready_o = (state_q == StIdle) && dc_win;
    ic_req_ready_o = (state_q == StIdle) && ic_win;
  end

  // Next-state logic for the FSM and the line assembly datapath.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dst_d   = dst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (dc_req_ready_o || ic_req_ready_o) begin
          addr_d  = (ic_req_ready_o ? ic_req_addr_i : dc_req_addr_i) & AlignMask;
          dst_d   = ic_req_ready_o;
          line_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StAr;
        end
      end
      StAr: begin
        if (ar_ready_i) state_d = StData;
      end
      StData: begin
        if (r_valid_i) begin
          line_d[cnt_q*DW +: DW] = r_data_i;
          if (r_resp_i != 2'b00) err_d = 1'b1;
          if (r_last_i) begin
            // Short burst leaves the remaining slots at zero.
            if (cnt_q != LastBeat) err_d = 1'b1;
            state_d = StDone;
          end else if (cnt_q == LastBeat) begin
            // Long burst: line is full, swallow the rest.
            err_d   = 1'b1;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (r_valid_i && r_last_i) state_d = StDone;
      end
      StDone: begin
        if (line_ready_i) begin
          last_d  = dst_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dst_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      line_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      last_q  <= last_d;
    end
  end

  // Outputs are decodes of registered state.
  always_comb begin
    ar_valid_o   = (state_q == StAr);
    r_ready_o    = (state_q == StData) || (state_q == StDrain);
    line_valid_o = (state_q == StDone);
    ar_addr_o    = addr_q;
    ar_len_o     = 8'(NB - 1);
    ar_id_o      = dst_q;
    line_data_o  = line_q;
    line_dst_o   = dst_q;
    line_err_o   = err_q;
  end

endmodule

// File: tb/tb_refill_axi_sched.sv
// Self-checking bench for refill_axi_sched (DW=8, NB=2, AW=32).
module tb_refill_axi_sched;

  localparam int unsigned DW = 8;
  localparam int unsigned NB = 2;
  localparam int unsigned AW = 32;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             dc_req_valid_i, dc_req_ready_o;
  logic [AW-1:0]    dc_req_addr_i;
  logic             ic_req_valid_i, ic_req_ready_o;
  logic [AW-1:0]    ic_req_addr_i;
  logic             ar_valid_o, ar_ready_i;
  logic [AW-1:0]    ar_addr_o;
  logic [7:0]       ar_len_o;
  logic             ar_id_o;
  logic             r_valid_i, r_ready_o;
  logic [DW-1:0]    r_data_i;
  logic             r_last_i;
  logic [1:0]       r_resp_i;
  logic             line_valid_o, line_ready_i;
  logic [NB*DW-1:0] line_data_o;
  logic             line_dst_o, line_err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit last_dst;  // bench's own record of the last granted requester

  refill_axi_sched #(.DW(DW), .NB(NB), .AW(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .dc_req_valid_i (dc_req_valid_i),
    .dc_req_ready_o (dc_req_ready_o),
    .dc_req_addr_i  (dc_req_addr_i),
    .ic_req_valid_i (ic_req_valid_i),
    .ic_req_ready_o (ic_req_ready_o),
    .ic_req_addr_i  (ic_req_addr_i),
    .ar_valid_o     (ar_valid_o),
    .ar_ready_i     (ar_ready_i),
    .ar_addr_o      (ar_addr_o),
    .ar_len_o       (ar_len_o),
    .ar_id_o        (ar_id_o),
    .r_valid_i      (r_valid_i),
    .r_ready_o      (r_ready_o),
    .r_data_i       (r_data_i),
    .r_last_i       (r_last_i),
    .r_resp_i       (r_resp_i),
    .line_valid_o   (line_valid_o),
    .line_ready_i   (line_ready_i),
    .line_data_o    (line_data_o),
    .line_dst_o     (line_dst_o),
    .line_err_o     (line_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          dcv;
    bit          icv;
    logic [31:0] dca;
    logic [31:0] ica;
    int          nbeats;
    logic [31:0] beats;    // beat i at [i*8 +: 8]
    logic [7:0]  resps;    // resp i at [i*2 +: 2]
    int          ar_stall;
    logic [3:0]  gaps;     // idle cycle before beat i
    int          rdly;
    bit          exp_dst;
    logic [31:0] exp_addr;
    logic [15:0] exp_data;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ar_valid", 64'(ar_valid_o), 0);
    check("rst_r_ready", 64'(r_ready_o), 0);
    check("rst_line_valid", 64'(line_valid_o), 0);
    check("rst_dc_ready", 64'(dc_req_ready_o), 0);
    check("rst_ic_ready", 64'(ic_req_ready_o), 0);
    check("rst_ar_addr", 64'(ar_addr_o), 0);
    check("rst_ar_id", 64'(ar_id_o), 0);
    check("rst_line_data", 64'(line_data_o), 0);
    check("rst_line_dst", 64'(line_dst_o), 0);
    check("rst_line_err", 64'(line_err_o), 0);
  endtask

  // One complete transaction: request, AR, R beats, line hand-back.
  task automatic txn(input vec_t v);
    int  t0;
    int  extra;
    bit  has_loser;
    has_loser = v.dcv && v.icv;
    extra = v.ar_stall;
    @(negedge clk);
    dc_req_valid_i = v.dcv;
    dc_req_addr_i  = v.dca;
    ic_req_valid_i = v.icv;
    ic_req_addr_i  = v.ica;
    t0 = cyc;
    #1;
    check("req_ready_dc", 64'(dc_req_ready_o), 64'(v.dcv && !v.exp_dst));
    check("req_ready_ic", 64'(ic_req_ready_o), 64'(v.icv && v.exp_dst));
    @(negedge clk);
    // Winner drops its request; a loser keeps waiting.
    if (v.exp_dst) ic_req_valid_i = 1'b0;
    else dc_req_valid_i = 1'b0;
    for (int s = 0; s <= v.ar_stall; s++) begin
      ar_ready_i = (s == v.ar_stall);
      #1;
      check("ar_valid", 64'(ar_valid_o), 1);
      check("ar_addr", 64'(ar_addr_o), 64'(v.exp_addr));
      check("ar_len", 64'(ar_len_o), NB - 1);
      check("ar_id", 64'(ar_id_o), 64'(v.exp_dst));
      check("ar_r_ready", 64'(r_ready_o), 0);
      if (has_loser) check("loser_ready_ar", 64'(dc_req_ready_o | ic_req_ready_o), 0);
      @(negedge clk);
    end
    ar_ready_i = 1'b0;
    for (int i = 0; i < v.nbeats; i++) begin
      if (v.gaps[i]) begin
        r_valid_i = 1'b0;
        extra++;
        #1;
        check("r_ready_gap", 64'(r_ready_o), 1);
        @(negedge clk);
      end
      r_valid_i = 1'b1;
      r_data_i  = v.beats[i*8 +: 8];
      r_resp_i  = v.resps[i*2 +: 2];
      r_last_i  = (i == v.nbeats - 1);
      #1;
      check("r_ready_beat", 64'(r_ready_o), 1);
      check("ar_valid_in_r", 64'(ar_valid_o), 0);
      if (has_loser) check("loser_ready_r", 64'(dc_req_ready_o | ic_req_ready_o), 0);
      @(negedge clk);
    end
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    r_resp_i  = 2'b00;
    #1;
    check("line_valid", 64'(line_valid_o), 1);
    check("latency", 64'(cyc - t0), 64'(v.nbeats + 2 + extra));
    check("line_data", 64'(line_data_o), 64'(v.exp_data));
    check("line_dst", 64'(line_dst_o), 64'(v.exp_dst));
    check("line_err", 64'(line_err_o), 64'(v.exp_err));
    check("done_r_ready", 64'(r_ready_o), 0);
    for (int k = 0; k < v.rdly; k++) begin
      @(negedge clk);
      #1;
      check("hold_valid", 64'(line_valid_o), 1);
      check("hold_data", 64'(line_data_o), 64'(v.exp_data));
      check("hold_err", 64'(line_err_o), 64'(v.exp_err));
    end
    line_ready_i = 1'b1;
    @(negedge clk);
    line_ready_i   = 1'b0;
    dc_req_valid_i = 1'b0;
    ic_req_valid_i = 1'b0;
    #1;
    check("line_valid_drop", 64'(line_valid_o), 0);
    last_dst = v.exp_dst;
  endtask

  function automatic vec_t mk(input bit dcv, input bit icv, input logic [31:0] dca,
                              input logic [31:0] ica, input int nbeats,
                              input logic [31:0] beats, input logic [7:0] resps,
                              input int rdly, input bit exp_dst, input logic [31:0] exp_addr,
                              input logic [15:0] exp_data, input bit exp_err);
    vec_t v;
    v.dcv = dcv; v.icv = icv; v.dca = dca; v.ica = ica;
    v.nbeats = nbeats; v.beats = beats; v.resps = resps;
    v.ar_stall = 0; v.gaps = 4'b0; v.rdly = rdly;
    v.exp_dst = exp_dst; v.exp_addr = exp_addr; v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  vec_t table_v[8];
  vec_t rv;

  initial begin
    rst_i = 1'b1;
    dc_req_valid_i = 0; dc_req_addr_i = 0; ic_req_valid_i = 0; ic_req_addr_i = 0;
    ar_ready_i = 0; r_valid_i = 0; r_data_i = 0; r_last_i = 0; r_resp_i = 0; line_ready_i = 0;
    last_dst = 1'b1;

    // Directed vectors; arbitration order starts from the reset pointer (icache last).
    table_v[0] = mk(1, 1, 32'h2000, 32'h3001, 2, 32'h2211, 8'h0, 0, 0, 32'h2000, 16'h2211, 0);
    table_v[1] = mk(1, 1, 32'h2000, 32'h3001, 2, 32'h4433, 8'h0, 0, 1, 32'h3000, 16'h4433, 0);
    table_v[2] = mk(1, 1, 32'h2000, 32'h3001, 2, 32'h6655, 8'h0, 0, 0, 32'h2000, 16'h6655, 0);
    table_v[3] = mk(1, 0, 32'h1003, 32'h0, 2, 32'hBBAA, 8'h0, 0, 0, 32'h1002, 16'hBBAA, 0);
    table_v[4] = mk(0, 1, 32'h0, 32'h4000, 1, 32'h5C, 8'h0, 0, 1, 32'h4000, 16'h005C, 1);
    table_v[5] = mk(1, 0, 32'h5007, 32'h0, 4, 32'h04030201, 8'h0, 0, 0, 32'h5006, 16'h0201, 1);
    table_v[6] = mk(0, 1, 32'h0, 32'h6000, 2, 32'h8877, 8'b0000_1000, 5, 1, 32'h6000, 16'h8877, 1);
    table_v[7] = mk(0, 1, 32'h0, 32'h7003, 2, 32'hF00D, 8'h0, 1, 1, 32'h7002, 16'hF00D, 0);
    table_v[7].ar_stall = 2;
    table_v[7].gaps = 4'b0010;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) txn(table_v[i]);

    // Reset in the middle of a burst, then a clean icache refill.
    @(negedge clk);
    dc_req_valid_i = 1'b1;
    dc_req_addr_i  = 32'h7005;
    @(negedge clk);
    dc_req_valid_i = 1'b0;
    ar_ready_i     = 1'b1;
    @(negedge clk);
    ar_ready_i = 1'b0;
    r_valid_i  = 1'b1;
    r_data_i   = 8'h99;
    @(negedge clk);
    r_valid_i = 1'b0;
    #1;
    check("mid_r_ready", 64'(r_ready_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst_i    = 1'b0;
    last_dst = 1'b1;
    txn(mk(0, 1, 32'h0, 32'h7001, 2, 32'h3412, 8'h0, 0, 1, 32'h7000, 16'h3412, 0));

    // Randomized transactions against a rule-level reference model.
    for (int n = 0; n < 40; n++) begin
      int  kind;
      int  nkeep;
      bit  any_resp;
      kind     = $urandom_range(0, 2);
      rv.dcv   = (kind != 1);
      rv.icv   = (kind != 0);
      rv.dca   = $urandom;
      rv.ica   = $urandom;
      rv.nbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : NB;
      rv.beats = $urandom;
      rv.resps = 8'h0;
      for (int i = 0; i < rv.nbeats; i++)
        if ($urandom_range(0, 9) == 0) rv.resps[i*2 +: 2] = 2'($urandom_range(1, 3));
      rv.ar_stall = $urandom_range(0, 2);
      rv.gaps  = 4'($urandom_range(0, 15));
      rv.rdly  = $urandom_range(0, 3);
      // Both asking: the one not served last time goes first.
      if (rv.dcv && rv.icv) rv.exp_dst = (last_dst == 1'b0);
      else rv.exp_dst = rv.icv;
      rv.exp_addr = (rv.exp_dst ? rv.ica : rv.dca) & ~32'((NB * DW / 8) - 1);
      nkeep = (rv.nbeats < NB) ? rv.nbeats : NB;
      rv.exp_data = 16'h0;
      for (int i = 0; i < nkeep; i++) rv.exp_data[i*8 +: 8] = rv.beats[i*8 +: 8];
      any_resp = 1'b0;
      for (int i = 0; i < rv.nbeats; i++) if (rv.resps[i*2 +: 2] != 2'b00) any_resp = 1'b1;
      rv.exp_err = (rv.nbeats != NB) || any_resp;
      txn(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
